// File: rtl/md_cart_pkg.sv
// Shared definitions for the cartridge bus bridge: FSM states, the
// save-RAM mapping register address, timeout fill value and default widths.
package md_cart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_HOLD,
    ST_WR_REQ,
    ST_DRAIN
  } state_e;

  // Low byte of the word address of $A130F1
  localparam logic [7:0]  SRAM_MAP_REG_ADDR = 8'h78;
  // Data returned to the 68k when a read is aborted
  localparam logic [15:0] TIMEOUT_FILL      = 16'hFFFF;

  localparam int DEF_ROM_AW  = 22;
  localparam int DEF_SRAM_AW = 14;

endpackage

// File: rtl/md_cart_sync_edge.sv
// Registers the cartridge strobes once, then produces aligned level and
// registered rising-edge pulses for read, write and $A130xx-write.
module md_cart_sync_edge (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_i,
  input  logic       oe_i,
  input  logic       lwr_i,
  input  logic       uwr_i,
  input  logic       time_i,
  output logic       rd_o,
  output logic       rd_rise_o,
  output logic       wr_rise_o,
  output logic       tw_rise_o,
  output logic [1:0] be_o
);

  logic       cs_q, oe_q, lwr_q, uwr_q, time_q;
  logic       rd_q, wr_q, tw_q;
  logic       rd_rise_q, wr_rise_q, tw_rise_q;
  logic [1:0] be_q;
  logic       rd_s, wr_s, tw_s;

  assign rd_s = cs_q & oe_q;
  assign wr_s = cs_q & (lwr_q | uwr_q);
  assign tw_s = time_q & lwr_q;

  // Stage 1 captures the raw strobes; stage 2 holds levels and edge pulses
  // so that a pulse and its level/byte-enables are always cycle-aligned.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_q      <= 1'b0;
      oe_q      <= 1'b0;
      lwr_q     <= 1'b0;
      uwr_q     <= 1'b0;
      time_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      tw_q      <= 1'b0;
      rd_rise_q <= 1'b0;
      wr_rise_q <= 1'b0;
      tw_rise_q <= 1'b0;
      be_q      <= 2'b00;
    end else begin
      cs_q      <= cs_i;
      oe_q      <= oe_i;
      lwr_q     <= lwr_i;
      uwr_q     <= uwr_i;
      time_q    <= time_i;
      rd_q      <= rd_s;
      wr_q      <= wr_s;
      tw_q      <= tw_s;
      rd_rise_q <= rd_s & ~rd_q;
      wr_rise_q <= wr_s & ~wr_q;
      tw_rise_q <= tw_s & ~tw_q;
      be_q      <= {uwr_q, lwr_q};
    end
  end

  assign rd_o      = rd_q;
  assign rd_rise_o = rd_rise_q;
  assign wr_rise_o = wr_rise_q;
  assign tw_rise_o = tw_rise_q;
  assign be_o      = be_q;

endmodule

// File: rtl/md_cart_bridge.sv
// Cartridge bus to generic word-memory bridge. Each read/write strobe edge
// becomes one held mem_req transaction; a timeout aborts stuck accesses.
// Build option MD_CART_SRAM_EN: enables the save-RAM window and the
// $A130F1 mapping register. Without it all writes are absorbed internally.
module md_cart_bridge
  import md_cart_pkg::*;
#(
  parameter int          ROM_AW    = DEF_ROM_AW,
  parameter logic [22:0] SRAM_BASE = 23'h100000,
  parameter int          SRAM_AW   = DEF_SRAM_AW,
  parameter int          TIMEOUT   = 63
) (
  input  logic        MCLK,
  input  logic        ext_reset,
  input  logic [22:0] cart_address,
  input  logic        cart_cs,
  input  logic        cart_oe,
  input  logic        cart_lwr,
  input  logic        cart_uwr,
  input  logic        cart_time,
  input  logic [15:0] cart_data_wr,
  output logic [15:0] cart_data,
  output logic        cart_data_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sram,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        sram_map,
  output logic        timeout_err
);

  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [22:0] ROM_MASK = 23'((64'd1 << ROM_AW) - 64'd1);

  logic       rd, rd_rise, wr_rise, tw_rise;
  logic [1:0] be;
  logic       map_en;
  logic       hit;
  logic [22:0] dec_addr;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_sram_q, mem_sram_d;
  logic [22:0]     mem_addr_q, mem_addr_d;
  logic [1:0]      mem_be_q, mem_be_d;
  logic [15:0]     mem_wdata_q, mem_wdata_d;
  logic [15:0]     cart_data_q, cart_data_d;
  logic            cart_data_en_q, cart_data_en_d;
  logic            timeout_err_q, timeout_err_d;
  logic            cnt_hit;

  md_cart_sync_edge u_sync (
    .clk_i     (MCLK),
    .rst_i     (ext_reset),
    .cs_i      (cart_cs),
    .oe_i      (cart_oe),
    .lwr_i     (cart_lwr),
    .uwr_i     (cart_uwr),
    .time_i    (cart_time),
    .rd_o      (rd),
    .rd_rise_o (rd_rise),
    .wr_rise_o (wr_rise),
    .tw_rise_o (tw_rise),
    .be_o      (be)
  );

`ifdef MD_CART_SRAM_EN
  logic sram_map_q;

  // Save-RAM mapping bit, written by a low-byte $A130F1 strobe while idle
  always_ff @(posedge MCLK) begin
    if (ext_reset)
      sram_map_q <= 1'b0;
    else if (state_q == ST_IDLE && tw_rise &&
             cart_address[7:0] == SRAM_MAP_REG_ADDR)
      sram_map_q <= cart_data_wr[0];
  end

  assign map_en = sram_map_q;
`else
  logic unused_tw;
  assign unused_tw = tw_rise;
  assign map_en    = 1'b0;
`endif

  // Save-RAM window only decodes while mapped in; everything else is ROM
  assign hit      = map_en && (cart_address[22:SRAM_AW] == SRAM_BASE[22:SRAM_AW]);
  assign dec_addr = hit ? 23'(cart_address[SRAM_AW-1:0]) : (cart_address & ROM_MASK);
  assign cnt_hit  = (cnt_q == CW'(TIMEOUT - 1));

  // State and output registers
  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_sram_q     <= 1'b0;
      mem_addr_q     <= '0;
      mem_be_q       <= 2'b00;
      mem_wdata_q    <= '0;
      cart_data_q    <= '0;
      cart_data_en_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_sram_q     <= mem_sram_d;
      mem_addr_q     <= mem_addr_d;
      mem_be_q       <= mem_be_d;
      mem_wdata_q    <= mem_wdata_d;
      cart_data_q    <= cart_data_d;
      cart_data_en_q <= cart_data_en_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // Next-state and output logic; mem_* only change when a request starts
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_sram_d     = mem_sram_q;
    mem_addr_d     = mem_addr_q;
    mem_be_d       = mem_be_q;
    mem_wdata_d    = mem_wdata_q;
    cart_data_d    = cart_data_q;
    cart_data_en_d = cart_data_en_q;
    timeout_err_d  = timeout_err_q;

    unique case (state_q)
      ST_IDLE: begin
        // Read wins over a write rising in the same cycle
        if (rd_rise) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_be_d   = 2'b11;
          mem_sram_d = hit;
          mem_addr_d = dec_addr;
          state_d    = ST_RD_REQ;
        end else if (wr_rise && hit) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_be_d    = be;
          mem_sram_d  = 1'b1;
          mem_addr_d  = dec_addr;
          mem_wdata_d = cart_data_wr;
          state_d     = ST_WR_REQ;
        end
        // Writes to ROM space are absorbed here without a request
      end

      ST_RD_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          cart_data_d = mem_rdata;
          if (rd) begin
            cart_data_en_d = 1'b1;
            state_d        = ST_RD_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!rd) begin
          state_d = ST_DRAIN;
        end else if (cnt_hit) begin
          mem_req_d      = 1'b0;
          timeout_err_d  = 1'b1;
          cart_data_d    = TIMEOUT_FILL;
          cart_data_en_d = 1'b1;
          state_d        = ST_RD_HOLD;
        end
      end

      ST_RD_HOLD: begin
        if (!rd) begin
          cart_data_en_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end

      ST_WR_REQ, ST_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (cnt_hit) begin
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Timeout counter restarts on every state change
    if (state_d != state_q) cnt_d = '0;
  end

  assign cart_data    = cart_data_q;
  assign cart_data_en = cart_data_en_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_sram     = mem_sram_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign sram_map     = map_en;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_md_cart_bridge.sv
// Directed bench for md_cart_bridge: reads, early release, save-RAM map,
// timeout, reset abort and read/write collision.
module tb_md_cart_bridge;

  logic        MCLK = 1'b0;
  logic        ext_reset;
  logic [22:0] cart_address;
  logic        cart_cs, cart_oe, cart_lwr, cart_uwr, cart_time;
  logic [15:0] cart_data_wr;
  logic [15:0] cart_data;
  logic        cart_data_en;
  logic        mem_req, mem_we, mem_sram;
  logic [22:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        sram_map, timeout_err;

  md_cart_bridge dut (
    .MCLK         (MCLK),
    .ext_reset    (ext_reset),
    .cart_address (cart_address),
    .cart_cs      (cart_cs),
    .cart_oe      (cart_oe),
    .cart_lwr     (cart_lwr),
    .cart_uwr     (cart_uwr),
    .cart_time    (cart_time),
    .cart_data_wr (cart_data_wr),
    .cart_data    (cart_data),
    .cart_data_en (cart_data_en),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sram     (mem_sram),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .sram_map     (sram_map),
    .timeout_err  (timeout_err)
  );

  always #5 MCLK = ~MCLK;

  int nchk = 0;
  int nerr = 0;

  // memory model controls and observations
  logic        resp_en = 1'b1;
  int          resp_lat = 3;
  logic [15:0] resp_data = 16'h0;
  int          stray_req = 0;
  int          stray_seen = 0;
  int          req_cnt = 0;
  int          cur_len = 0;
  int          last_len = 0;
  int          unstable = 0;
  logic        prev_req = 1'b0;
  logic [42:0] cap_vec = '0;
  logic        cap_we, cap_sram;
  logic [22:0] cap_addr;
  logic [1:0]  cap_be;
  logic [15:0] cap_wdata;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic wait_en(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge MCLK);
      n++;
      if (cart_data_en) break;
    end
  endtask

  // Memory responder: acts shortly after each rising edge, acks after
  // resp_lat cycles of mem_req, captures request fields at request start.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(posedge MCLK);
      #2;
      mem_ack = 1'b0;
      if (stray_req != stray_seen) begin
        mem_ack    = 1'b1;
        mem_rdata  = resp_data;
        stray_seen = stray_req;
      end
      if (mem_req) begin
        if (!prev_req) begin
          req_cnt++;
          cur_len   = 0;
          cap_vec   = {mem_we, mem_sram, mem_addr, mem_be, mem_wdata};
          cap_we    = mem_we;
          cap_sram  = mem_sram;
          cap_addr  = mem_addr;
          cap_be    = mem_be;
          cap_wdata = mem_wdata;
        end else if ({mem_we, mem_sram, mem_addr, mem_be, mem_wdata} != cap_vec) begin
          unstable++;
        end
        cur_len++;
        if (resp_en && cur_len == resp_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = resp_data;
        end
      end else if (prev_req) begin
        last_len = cur_len;
      end
      prev_req = mem_req;
    end
  end

  task automatic tw_write(input logic [15:0] d);
    cart_address = 23'h509878;
    cart_data_wr = d;
    cart_time = 1'b1; cart_lwr = 1'b1;
    tick(4);
    cart_time = 1'b0; cart_lwr = 1'b0;
    tick(3);
  endtask

  initial begin
    int n, base;
    logic en_seen;
    ext_reset = 1'b1;
    cart_address = '0; cart_cs = 0; cart_oe = 0; cart_lwr = 0; cart_uwr = 0;
    cart_time = 0; cart_data_wr = '0;
    tick(3);
    chk("rst_req", mem_req, 0);
    chk("rst_en", cart_data_en, 0);
    chk("rst_data", cart_data, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_map", sram_map, 0);
    chk("rst_terr", timeout_err, 0);
    ext_reset = 1'b0;
    tick(2);

    // basic read
    resp_lat = 3; resp_data = 16'h4E71;
    cart_address = 23'h000100; cart_cs = 1; cart_oe = 1;
    wait_en(20, n);
    chk("rd_lat", n, 6);
    chk("rd_data", cart_data, 16'h4E71);
    chk("rd_addr", cap_addr, 23'h000100);
    chk("rd_be", cap_be, 2'b11);
    chk("rd_we", cap_we, 0);
    chk("rd_sram", cap_sram, 0);
    tick(3);
    chk("rd_hold", cart_data_en, 1);
    cart_oe = 0;
    tick(3);
    chk("rd_release", cart_data_en, 0);
    chk("rd_keep", cart_data, 16'h4E71);
    cart_cs = 0;
    tick(3);

    // early release with ignored edge during drain
    resp_lat = 10; resp_data = 16'hAAAA;
    base = req_cnt; en_seen = 0;
    cart_address = 23'h000200; cart_cs = 1; cart_oe = 1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (cart_data_en) en_seen = 1;
      if (i == 4) cart_oe = 0;
      if (i == 6) cart_oe = 1;
      if (i == 7) cart_oe = 0;
    end
    chk("er_reqs", req_cnt - base, 1);
    chk("er_len", last_len, 10);
    chk("er_no_en", en_seen, 0);
    chk("er_terr", timeout_err, 0);
    resp_lat = 2; resp_data = 16'h1234;
    cart_address = 23'h000300; cart_oe = 1;
    wait_en(20, n);
    chk("er_next_en", cart_data_en, 1);
    chk("er_next_data", cart_data, 16'h1234);
    chk("er_next_addr", cap_addr, 23'h000300);
    chk("er_next_reqs", req_cnt - base, 2);
    cart_oe = 0; cart_cs = 0;
    tick(4);

    // save-RAM mapping
    resp_lat = 2;
    tw_write(16'h0001);
    base = req_cnt;
`ifdef MD_CART_SRAM_EN
    chk("map_set", sram_map, 1);
`else
    chk("map_set", sram_map, 0);
`endif
    chk("map_noreq", req_cnt - base, 0);
    cart_address = 23'h100004; cart_data_wr = 16'h00AB;
    cart_cs = 1; cart_lwr = 1;
    tick(8);
    cart_cs = 0; cart_lwr = 0;
    tick(3);
`ifdef MD_CART_SRAM_EN
    chk("sw_reqs", req_cnt - base, 1);
    chk("sw_sram", cap_sram, 1);
    chk("sw_addr", cap_addr, 23'h4);
    chk("sw_be", cap_be, 2'b01);
    chk("sw_we", cap_we, 1);
    chk("sw_wdata", cap_wdata, 16'h00AB);
`else
    chk("sw_reqs", req_cnt - base, 0);
`endif
    tw_write(16'h0000);
    chk("map_clr", sram_map, 0);
    base = req_cnt;
    cart_cs = 1; cart_lwr = 1;
    tick(8);
    cart_cs = 0; cart_lwr = 0;
    tick(3);
    chk("rw_noreq", req_cnt - base, 0);

    // timeout
    resp_en = 0;
    cart_address = 23'h000400; cart_cs = 1; cart_oe = 1;
    wait_en(100, n);
    chk("to_lat", n, 66);
    chk("to_len", last_len, 63);
    chk("to_err", timeout_err, 1);
    chk("to_data", cart_data, 16'hFFFF);
    tick(2);
    chk("to_hold", cart_data_en, 1);
    cart_oe = 0;
    tick(3);
    chk("to_release", cart_data_en, 0);
    chk("to_sticky", timeout_err, 1);
    cart_cs = 0;
    tick(3);

    // reset during RD_REQ, then stray ack
    cart_address = 23'h000600; cart_cs = 1; cart_oe = 1;
    tick(4);
    chk("rr_req_up", mem_req, 1);
    ext_reset = 1; cart_cs = 0; cart_oe = 0;
    tick(1);
    chk("rr_req", mem_req, 0);
    chk("rr_map", sram_map, 0);
    chk("rr_terr", timeout_err, 0);
    chk("rr_en", cart_data_en, 0);
    ext_reset = 0;
    tick(2);
    base = req_cnt;
    resp_data = 16'hBEEF;
    stray_req++;
    tick(4);
    chk("sa_req", mem_req, 0);
    chk("sa_en", cart_data_en, 0);
    chk("sa_data", cart_data, 0);
    chk("sa_reqs", req_cnt - base, 0);

    // simultaneous read and write rise
    resp_en = 1; resp_lat = 2; resp_data = 16'h5A5A;
    base = req_cnt;
    cart_address = 23'h000500; cart_data_wr = 16'h1111;
    cart_cs = 1; cart_oe = 1; cart_lwr = 1; cart_uwr = 1;
    wait_en(20, n);
    chk("rw_en", cart_data_en, 1);
    chk("rw_we", cap_we, 0);
    chk("rw_data", cart_data, 16'h5A5A);
    chk("rw_addr", cap_addr, 23'h000500);
    cart_cs = 0; cart_oe = 0; cart_lwr = 0; cart_uwr = 0;
    tick(8);
    chk("rw_reqs", req_cnt - base, 1);
    chk("stable", unstable, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
